// File: rtl/dog_window_buffer_pkg.sv
// Shared types and helpers for the DoG sliding-window buffer.
// Holds the FSM state enum, the packed-window index helper and a constant-safe clog2.
package sift_pkg;

  localparam int DATA_W_DEF = 17;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_e;

  // Usable in parameter expressions; never returns less than 1 bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  function automatic int win_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage

// File: rtl/dog_window_buffer_line_ram.sv
// One row of sample storage: a single write port and a registered read port.
// Read and write addresses are independent.
module dog_line_ram
  import sift_pkg::*;
#(
  parameter int DEPTH = 252,
  parameter int WIDTH = DATA_W_DEF,
  parameter int AW    = clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dog_window_buffer.sv
// KxK sliding-window generator over a raster stream of signed DoG samples.
// K line RAMs form a ring; a two-stage pipeline assembles one window column per accepted sample.
module dog_window_buffer
  import sift_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int K      = 3,
  parameter int IMG_W  = 252,
  parameter int IMG_H  = 252,
  parameter int XW     = 8,
  parameter int YW     = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  in_valid_i,
  input  logic                  in_sof_i,
  input  logic [DATA_W-1:0]     in_data_i,
  output logic                  win_valid_o,
  output logic [K*K*DATA_W-1:0] win_data_o,
  output logic [XW-1:0]         win_x_o,
  output logic [YW-1:0]         win_y_o,
  output logic                  frame_done_o,
  output logic                  overflow_o
);

  localparam int RAW  = clog2(IMG_W);
  localparam int SW   = clog2(K);
  localparam int HALF = (K - 1) / 2;

  state_e state_q, state_d;
  logic restart, accept, set_ovf, last_px;
  logic [XW-1:0] x_q, cur_x;
  logic [YW-1:0] y_q, cur_y;
  logic [SW-1:0] wr_sel_q, cur_sel;
  logic overflow_q;

  logic [DATA_W-1:0] rd_data [K];
  logic              s1_valid_q;
  logic [XW-1:0]     s1_x_q;
  logic [YW-1:0]     s1_y_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [SW-1:0]     s1_sel_q;
  logic [DATA_W-1:0] col [K];
  logic [DATA_W-1:0] win_q [K][K];
  logic              win_valid_q, frame_done_q;
  logic [XW-1:0]     win_x_q;
  logic [YW-1:0]     win_y_q;

  assign last_px = (x_q == XW'(IMG_W - 1)) && (y_q == YW'(IMG_H - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (in_valid_i && in_sof_i) state_d = ACTIVE;
    else if (in_valid_i && state_q == ACTIVE && last_px) state_d = DONE;
  end

  always_comb begin
    restart = in_valid_i && in_sof_i;
    accept  = restart || (in_valid_i && state_q == ACTIVE);
    set_ovf = in_valid_i && !in_sof_i && state_q == DONE;
  end

  // A start-of-frame sample is itself pixel (0,0), so it bypasses the stored counters.
  assign cur_x   = restart ? '0 : x_q;
  assign cur_y   = restart ? '0 : y_q;
  assign cur_sel = restart ? '0 : wr_sel_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q        <= '0;
      y_q        <= '0;
      wr_sel_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        if (cur_x == XW'(IMG_W - 1)) begin
          x_q      <= '0;
          y_q      <= cur_y + YW'(1);
          wr_sel_q <= (cur_sel == SW'(K - 1)) ? '0 : cur_sel + SW'(1);
        end else begin
          x_q      <= cur_x + XW'(1);
          y_q      <= cur_y;
          wr_sel_q <= cur_sel;
        end
      end
      if (restart)      overflow_q <= 1'b0;
      else if (set_ovf) overflow_q <= 1'b1;
    end
  end

  for (genvar g = 0; g < K; g++) begin : g_ram
    dog_line_ram #(
      .DEPTH(IMG_W),
      .WIDTH(DATA_W),
      .AW   (RAW)
    ) u_ram (
      .clk_i  (clk_i),
      .we_i   (accept && (cur_sel == SW'(g))),
      .waddr_i(cur_x[RAW-1:0]),
      .wdata_i(in_data_i),
      .raddr_i(cur_x[RAW-1:0]),
      .rdata_o(rd_data[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid_q <= 1'b0;
      s1_x_q     <= '0;
      s1_y_q     <= '0;
      s1_data_q  <= '0;
      s1_sel_q   <= '0;
    end else begin
      s1_valid_q <= accept;
      if (accept) begin
        s1_x_q    <= cur_x;
        s1_y_q    <= cur_y;
        s1_data_q <= in_data_i;
        s1_sel_q  <= cur_sel;
      end
    end
  end

  // The RAM just after the write pointer holds the oldest row; the live sample is the newest.
  always_comb begin
    for (int r = 0; r < K; r++) col[r] = '0;
    for (int r = 0; r < K - 1; r++) begin
      for (int g = 0; g < K; g++) begin
        if (g == (int'(s1_sel_q) + 1 + r) % K) col[r] = rd_data[g];
      end
    end
    col[K-1] = s1_data_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) win_q[r][c] <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_x_q      <= '0;
      win_y_q      <= '0;
    end else begin
      if (s1_valid_q) begin
        for (int r = 0; r < K; r++) begin
          for (int c = 0; c < K - 1; c++) win_q[r][c] <= win_q[r][c+1];
          win_q[r][K-1] <= col[r];
        end
        win_x_q <= s1_x_q - XW'(HALF);
        win_y_q <= s1_y_q - YW'(HALF);
      end
      win_valid_q  <= s1_valid_q && (s1_x_q >= XW'(K - 1)) && (s1_y_q >= YW'(K - 1));
      frame_done_q <= s1_valid_q && (s1_x_q == XW'(IMG_W - 1)) && (s1_y_q == YW'(IMG_H - 1));
    end
  end

  always_comb begin
    win_data_o = '0;
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++)
        win_data_o[win_idx(r, c, K)*DATA_W +: DATA_W] = win_q[r][c];
  end

  assign win_valid_o  = win_valid_q;
  assign win_x_o      = win_x_q;
  assign win_y_o      = win_y_q;
  assign frame_done_o = frame_done_q;
  assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_dog_window_buffer.sv
// Randomized bench for dog_window_buffer: a K=3 8x6 and a K=5 9x7 instance checked
// against an image-array reference model that predicts every window and its arrival cycle.
module tb_dog_window_buffer;

  localparam int DW = 17;
  localparam int K0 = 3, W0 = 8, H0 = 6;
  localparam int K1 = 5, W1 = 9, H1 = 7;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic v0 = 0, s0 = 0, v1 = 0, s1 = 0;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic wv0, fd0, ov0, wv1, fd1, ov1;
  logic [K0*K0*DW-1:0] wd0;
  logic [K1*K1*DW-1:0] wd1;
  logic [7:0] wx0, wy0, wx1, wy1;

  dog_window_buffer #(.DATA_W(DW), .K(K0), .IMG_W(W0), .IMG_H(H0), .XW(8), .YW(8)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v0), .in_sof_i(s0), .in_data_i(d0),
    .win_valid_o(wv0), .win_data_o(wd0), .win_x_o(wx0), .win_y_o(wy0),
    .frame_done_o(fd0), .overflow_o(ov0));

  dog_window_buffer #(.DATA_W(DW), .K(K1), .IMG_W(W1), .IMG_H(H1), .XW(8), .YW(8)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(v1), .in_sof_i(s1), .in_data_i(d1),
    .win_valid_o(wv1), .win_data_o(wd1), .win_x_o(wx1), .win_y_o(wy1),
    .frame_done_o(fd1), .overflow_o(ov1));

  typedef struct {
    int due;
    int cx;
    int cy;
    bit fd;
    int d[25];
  } win_t;

  int kk[2] = '{K0, K1};
  int ww[2] = '{W0, W1};
  int hh[2] = '{H0, H1};
  int img[2][7][9];
  int mx[2], my[2];
  bit inFrame[2], frameEnded[2], mOvf[2];
  win_t expq0[$], expq1[$];
  int winCount[2], fdCount[2];
  int centreElem22;
  bit firstSeen1;
  int firstX1, firstY1;
  int cyc = 0;
  int nChecks = 0, nFails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int expSize(input int i);
    return (i == 0) ? expq0.size() : expq1.size();
  endfunction

  function automatic int frontDue(input int i);
    return (i == 0) ? expq0[0].due : expq1[0].due;
  endfunction

  function automatic win_t popExp(input int i);
    if (i == 0) return expq0.pop_front();
    return expq1.pop_front();
  endfunction

  function automatic void modelReset();
    for (int i = 0; i < 2; i++) begin
      inFrame[i] = 0;
      frameEnded[i] = 0;
      mOvf[i] = 0;
    end
    expq0.delete();
    expq1.delete();
  endfunction

  // Reference: pixels land in a 2-D image; a window is due 2 cycles after its bottom-right pixel.
  function automatic void modelAccept(input int i, input bit v, input bit sof, input int d);
    win_t e;
    int k;
    k = kk[i];
    if (!v) return;
    if (sof) begin
      inFrame[i] = 1;
      frameEnded[i] = 0;
      mOvf[i] = 0;
      mx[i] = 0;
      my[i] = 0;
    end else if (!inFrame[i]) begin
      if (frameEnded[i]) mOvf[i] = 1;
      return;
    end
    img[i][my[i]][mx[i]] = d;
    if (mx[i] >= k - 1 && my[i] >= k - 1) begin
      e.due = cyc + 2;
      e.cx = mx[i] - (k - 1) / 2;
      e.cy = my[i] - (k - 1) / 2;
      e.fd = (mx[i] == ww[i] - 1) && (my[i] == hh[i] - 1);
      for (int n = 0; n < 25; n++) e.d[n] = 0;
      for (int r = 0; r < k; r++)
        for (int c = 0; c < k; c++)
          e.d[r*k+c] = img[i][my[i]-(k-1)+r][mx[i]-(k-1)+c];
      if (i == 0) expq0.push_back(e);
      else        expq1.push_back(e);
    end
    mx[i]++;
    if (mx[i] == ww[i]) begin
      mx[i] = 0;
      my[i]++;
      if (my[i] == hh[i]) begin
        inFrame[i] = 0;
        frameEnded[i] = 1;
      end
    end
  endfunction

  task automatic monitorWin(input int i, input logic wv, input logic [K1*K1*DW-1:0] wd,
                            input logic [7:0] wx, input logic [7:0] wy, input logic fd);
    win_t e;
    int k;
    logic signed [DW-1:0] el;
    k = kk[i];
    if (wv) begin
      winCount[i]++;
      if (fd) fdCount[i]++;
      if (i == 0 && wx == 8'd1 && wy == 8'd1) begin
        el = wd[(2*k+2)*DW +: DW];
        centreElem22 = int'(el);
      end
      if (i == 1 && !firstSeen1) begin
        firstSeen1 = 1;
        firstX1 = int'(wx);
        firstY1 = int'(wy);
      end
      if (expSize(i) == 0) begin
        checkOutput("unexpected_win", 1, 0);
      end else begin
        e = popExp(i);
        checkOutput("win_latency", cyc, e.due);
        checkOutput("win_x", longint'(wx), e.cx);
        checkOutput("win_y", longint'(wy), e.cy);
        checkOutput("frame_done", longint'(fd), longint'(e.fd));
        for (int n = 0; n < k * k; n++) begin
          el = wd[n*DW +: DW];
          checkOutput("win_elem", longint'(el), e.d[n]);
        end
      end
    end else begin
      if (fd) checkOutput("fd_without_valid", 1, 0);
      if (expSize(i) > 0 && frontDue(i) <= cyc) begin
        checkOutput("missing_win", 0, 1);
        e = popExp(i);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      monitorWin(0, wv0, {{((K1*K1-K0*K0)*DW){1'b0}}, wd0}, wx0, wy0, fd0);
      monitorWin(1, wv1, wd1, wx1, wy1, fd1);
    end
  end

  task automatic applyStimulus(input int i, input bit v, input bit sof, input int d);
    @(posedge clk);
    #1;
    v0 = 0; s0 = 0; v1 = 0; s1 = 0;
    if (i == 0) begin
      v0 = v; s0 = sof; d0 = DW'(d);
    end else begin
      v1 = v; s1 = sof; d1 = DW'(d);
    end
    modelAccept(i, v, sof, d);
  endtask

  task automatic idleCycles(input int n);
    for (int j = 0; j < n; j++) applyStimulus(0, 0, 0, 0);
  endtask

  // mode 0 ramp, 1 negative ramp, 2 random; stops before (stopX,stopY) when given.
  task automatic sendFrame(input int i, input int mode, input bit gaps,
                           input int stopX, input int stopY);
    int val;
    for (int y = 0; y < hh[i]; y++) begin
      for (int x = 0; x < ww[i]; x++) begin
        if (x == stopX && y == stopY) return;
        while (gaps && $urandom_range(0, 1) == 1)
          applyStimulus(i, 0, bit'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
        case (mode)
          0:       val = y * 16 + x;
          1:       val = -(y * 16 + x);
          default: val = int'($urandom_range(0, (1 << DW) - 1)) - (1 << (DW - 1));
        endcase
        applyStimulus(i, 1, (x == 0 && y == 0), val);
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base0, base1;
    modelReset();
    repeat (3) @(posedge clk);
    #2;
    checkOutput("rst_win_valid0", wv0, 0);
    checkOutput("rst_win_data0", longint'(wd0 != '0), 0);
    checkOutput("rst_win_x0", wx0, 0);
    checkOutput("rst_frame_done0", fd0, 0);
    checkOutput("rst_overflow0", ov0, 0);
    checkOutput("rst_win_valid1", wv1, 0);
    rst_n = 1'b1;

    // Samples before any start-of-frame are dropped.
    for (int j = 0; j < 4; j++) applyStimulus(0, 1, 0, 7);
    idleCycles(4);
    checkOutput("idle_no_win", winCount[0], 0);
    checkOutput("idle_no_ovf", ov0, 0);

    sendFrame(0, 0, 0, -1, -1);
    idleCycles(5);
    checkOutput("ramp_count", winCount[0], 24);
    checkOutput("ramp_fd_count", fdCount[0], 1);
    checkOutput("ramp_centre_elem22", centreElem22, 34);

    base0 = winCount[0];
    sendFrame(0, 0, 1, -1, -1);
    idleCycles(5);
    checkOutput("gap_count", winCount[0] - base0, 24);

    sendFrame(0, 1, 0, -1, -1);
    idleCycles(5);
    checkOutput("neg_centre_elem22", centreElem22, -34);

    base0 = winCount[0];
    for (int j = 0; j < 3; j++) applyStimulus(0, 1, 0, 55 + j);
    idleCycles(4);
    checkOutput("overflow_set", ov0, 1);
    checkOutput("overflow_model", ov0, longint'(mOvf[0]));
    checkOutput("no_win_after_done", winCount[0] - base0, 0);

    // Partial random frame restarted at (4,3), then a full random frame with gaps.
    base0 = winCount[0];
    applyStimulus(0, 1, 1, 5);
    applyStimulus(0, 0, 0, 0);
    checkOutput("overflow_cleared", ov0, 0);
    idleCycles(3);
    base0 = winCount[0];
    sendFrame(0, 2, 0, 4, 3);
    sendFrame(0, 2, 1, -1, -1);
    idleCycles(5);
    checkOutput("restart_count", winCount[0] - base0, 8 + 24);

    firstSeen1 = 0;
    base1 = winCount[1];
    sendFrame(1, 0, 0, -1, -1);
    idleCycles(5);
    checkOutput("k5_count", winCount[1] - base1, 15);
    checkOutput("k5_first_x", firstX1, 2);
    checkOutput("k5_first_y", firstY1, 2);
    checkOutput("k5_fd_count", fdCount[1], 1);

    // Reset pulsed mid-row while windows are in flight.
    sendFrame(1, 2, 0, 4, 3);
    #2;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("async_rst_valid1", wv1, 0);
    checkOutput("async_rst_data1", longint'(wd1 != '0), 0);
    checkOutput("async_rst_x1", wx1, 0);
    checkOutput("async_rst_y1", wy1, 0);
    checkOutput("async_rst_valid0", wv0, 0);
    v1 = 0;
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    base1 = winCount[1];
    for (int j = 0; j < 6; j++) applyStimulus(1, 1, 0, j);
    idleCycles(5);
    checkOutput("post_rst_idle_win", winCount[1] - base1, 0);
    checkOutput("post_rst_idle_ovf", ov1, 0);

    base1 = winCount[1];
    sendFrame(1, 2, 1, -1, -1);
    idleCycles(6);
    checkOutput("k5_rand_count", winCount[1] - base1, 15);
    checkOutput("queue0_empty", expq0.size(), 0);
    checkOutput("queue1_empty", expq1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
